mmio_write_arbiter: RTL
=======================

Name: mmio_write_arbiter

Overview:
- Shares the single write port of the MMIO peripheral register bank (base 0x0000_4000, word-spaced) between two requesters: the CPU store path (cpu_*) and the debug/host loader (dbg_*).
- Arbitrates and latches one write at a time.
- Range- and alignment-checks the address, drives a one-cycle write strobe to the bank, and returns a done/err response to the winning requester.

Parameters:
- BASE_ADDR, 32'h0000_4000: byte address of register 0.
- NUM_REGS, 5: number of 32-bit registers; valid addresses are BASE_ADDR + 4*k, k = 0..NUM_REGS-1.
- CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU write request; held high until cpu_done.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted and latched.
- cpu_done  out  1  one-cycle pulse: CPU transaction finished.
- cpu_err  out  1  valid with cpu_done; 1 = address rejected, no write.
- dbg_req, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_err: same widths and meanings for the debug requester.
- mm_we  out  1  write strobe to the register bank.
- mm_addr  out  32  latched byte address to the bank.
- mm_wdata  out  32  latched write data to the bank.
- busy  out  1  high whenever state != IDLE.
- err_cnt  out  CNT_W  saturating count of rejected writes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; mm_addr/mm_wdata=0; err_cnt=0; rr pointer=CPU-first. A write in flight is aborted and mm_we falls immediately. No done is issued for the aborted transaction.
- FSM: IDLE -> GRANT -> WRITE -> RESP -> IDLE. Every transaction is exactly 4 cycles; no back-to-back overlap.
- IDLE: if any req is high at edge N, latch the winner id, its addr and wdata; go to GRANT. Otherwise stay.
- GRANT (cycle N+1): assert the winner's gnt. Decode: valid = (addr[1:0]==0) and (BASE_ADDR <= addr <= BASE_ADDR+4*(NUM_REGS-1)), compared in 32-bit unsigned arithmetic. Register valid.
- WRITE (cycle N+2): if valid, mm_we=1 with the latched mm_addr/mm_wdata. If invalid, mm_we stays 0 and err_cnt increments; it saturates at 2^CNT_W-1 with no wrap.
- RESP (cycle N+3): pulse the winner's done; winner's err = !valid. Loser's outputs stay 0.
- Latched addr/data are frozen from IDLE capture until IDLE re-entry; input changes during a transaction are ignored.
- Requester dropping req mid-transaction does not abort it; done is still pulsed.
- Requester still holding req in the IDLE cycle after RESP is treated as a new request. Requesters must drop req on the cycle done is seen.
- A request arriving while busy waits; no request is lost while req is held.
- mm_addr/mm_wdata hold their last values when mm_we=0.

Optional Feature:
- Macro: MMIO_RR_ARB_EN.
- Defined: round-robin arbitration. A 1-bit last-winner pointer updates in GRANT. On simultaneous requests the non-last-winner wins. After reset the CPU wins the first tie.
- Undefined: fixed priority; CPU always wins ties, and the debug port can starve under continuous CPU traffic.

Decomposition:
- Shared package mmio_pkg: BASE_ADDR default, NUM_REGS, state encoding constants (IDLE=2'd0, GRANT=2'd1, WRITE=2'd2, RESP=2'd3), requester ids (REQ_CPU=1'b0, REQ_DBG=1'b1).
- One sub-module: mmio_addr_decode, combinational. Inputs: addr. Outputs: valid and a 3-bit register index. Reusable by a future read-side arbiter.

Test Plan:
- Single CPU write: cpu_req=1, cpu_addr=0x4008, cpu_wdata=0xDEADBEEF at edge 0 -> cpu_gnt at cycle 1; mm_we=1 with mm_addr=0x4008, mm_wdata=0xDEADBEEF at cycle 2; cpu_done=1, cpu_err=0 at cycle 3; busy high for cycles 1-3.
- Bad addresses: dbg writes to 0x4014 (out of range), then 0x4002 (misaligned) -> mm_we never asserts; dbg_err=1 with each dbg_done; err_cnt=2.
- Simultaneous requests to 0x4000 and 0x4004, both held until done:
  - without MMIO_RR_ARB_EN: order CPU, CPU, CPU for repeated CPU requests; debug starves;
  - with MMIO_RR_ARB_EN: order CPU, DBG, CPU, DBG.
- Reset mid-transaction: assert rst=0 during WRITE -> mm_we falls without a clock; no done pulse. After release, a new cpu_req to 0x4010 completes normally with err=0.
- Saturation: 300 invalid writes with CNT_W=8 -> err_cnt stops at 255.
- Input hold-off: change cpu_addr from 0x4004 to 0x5000 during GRANT -> write still goes to 0x4004; err=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO register-bank write arbiter and its address decoder.
package mmio_pkg;

   localparam logic [31:0] MMIO_BASE_ADDR = 32'h0000_4000;
   localparam int          MMIO_NUM_REGS  = 5;
   localparam int          MMIO_CNT_W     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } req_id_t;

   // Byte address of the highest register in a bank of num word-spaced registers.
   function automatic logic [31:0] last_reg_addr(input logic [31:0] base, input int num);
      return base + 32'(4 * (num - 1));
   endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational range/alignment check for the MMIO register bank; shared by the
// write arbiter and any future read-side arbiter.
module mmio_addr_decode
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = MMIO_BASE_ADDR,
   parameter int          NUM_REGS  = MMIO_NUM_REGS
) (
   input  logic [31:0] addr,
   output logic        valid,
   output logic [2:0]  reg_idx
);

   localparam logic [31:0] LAST_ADDR = last_reg_addr(BASE_ADDR, NUM_REGS);

   always_comb begin
      valid   = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
      reg_idx = 3'((addr - BASE_ADDR) >> 2);
   end

endmodule

// File: rtl/mmio_write_arbiter.sv
// Two-requester (CPU / debug) write arbiter for the MMIO register bank.
// Define MMIO_RR_ARB_EN for round-robin ties; otherwise the CPU always wins ties.
//
// state | meaning
// IDLE  | waiting for a request; winner, address and data are latched on exit
// GRANT | winner's gnt pulses; address decode result is registered
// WRITE | mm_we pulses if the address was valid, else err_cnt bumps
// RESP  | winner's done pulses with err = !valid
module mmio_write_arbiter
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = MMIO_BASE_ADDR,
   parameter int          NUM_REGS  = MMIO_NUM_REGS,
   parameter int          CNT_W     = MMIO_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic             cpu_gnt,
   output logic             cpu_done,
   output logic             cpu_err,
   input  logic             dbg_req,
   input  logic [31:0]      dbg_addr,
   input  logic [31:0]      dbg_wdata,
   output logic             dbg_gnt,
   output logic             dbg_done,
   output logic             dbg_err,
   output logic             mm_we,
   output logic [31:0]      mm_addr,
   output logic [31:0]      mm_wdata,
   output logic             busy,
   output logic [CNT_W-1:0] err_cnt
);

   state_t           state_q, state_d;
   req_id_t          win_q, win_d;
   req_id_t          arb_win;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             valid_q, valid_d;
   logic [31:0]      mm_addr_q, mm_addr_d;
   logic [31:0]      mm_wdata_q, mm_wdata_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             dec_valid;
   logic [2:0]       dec_idx;
   logic             any_req;

`ifdef MMIO_RR_ARB_EN
   req_id_t          last_q, last_d;
`endif

   assign any_req = cpu_req | dbg_req;

   mmio_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .NUM_REGS  (NUM_REGS)
   ) u_decode (
      .addr    (addr_q),
      .valid   (dec_valid),
      .reg_idx (dec_idx)
   );

   always_comb begin
      arb_win = REQ_CPU;
`ifdef MMIO_RR_ARB_EN
      if (cpu_req && dbg_req) begin
         arb_win = (last_q == REQ_CPU) ? REQ_DBG : REQ_CPU;
      end else if (dbg_req) begin
         arb_win = REQ_DBG;
      end
`else
      if (!cpu_req && dbg_req) begin
         arb_win = REQ_DBG;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = GRANT;
         GRANT:   state_d = WRITE;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q      <= REQ_CPU;
         addr_q     <= '0;
         wdata_q    <= '0;
         valid_q    <= 1'b0;
         mm_addr_q  <= '0;
         mm_wdata_q <= '0;
         err_cnt_q  <= '0;
`ifdef MMIO_RR_ARB_EN
         last_q     <= REQ_DBG;
`endif
      end else begin
         win_q      <= win_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         valid_q    <= valid_d;
         mm_addr_q  <= mm_addr_d;
         mm_wdata_q <= mm_wdata_d;
         err_cnt_q  <= err_cnt_d;
`ifdef MMIO_RR_ARB_EN
         last_q     <= last_d;
`endif
      end
   end

   always_comb begin
      win_d      = win_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      valid_d    = valid_q;
      mm_addr_d  = mm_addr_q;
      mm_wdata_d = mm_wdata_q;
      err_cnt_d  = err_cnt_q;
`ifdef MMIO_RR_ARB_EN
      last_d     = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               win_d   = arb_win;
               addr_d  = (arb_win == REQ_DBG) ? dbg_addr  : cpu_addr;
               wdata_d = (arb_win == REQ_DBG) ? dbg_wdata : cpu_wdata;
            end
         end
         GRANT: begin
            valid_d = dec_valid;
            // Bank outputs only move for writes that will actually happen.
            if (dec_valid) begin
               mm_addr_d  = BASE_ADDR + {27'd0, dec_idx, 2'b00};
               mm_wdata_d = wdata_q;
            end
`ifdef MMIO_RR_ARB_EN
            last_d = win_q;
`endif
         end
         WRITE: begin
            if (!valid_q && (err_cnt_q != '1)) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      cpu_gnt  = (state_q == GRANT) && (win_q == REQ_CPU);
      dbg_gnt  = (state_q == GRANT) && (win_q == REQ_DBG);
      mm_we    = (state_q == WRITE) && valid_q;
      cpu_done = (state_q == RESP)  && (win_q == REQ_CPU);
      dbg_done = (state_q == RESP)  && (win_q == REQ_DBG);
      cpu_err  = cpu_done && !valid_q;
      dbg_err  = dbg_done && !valid_q;
   end

   assign mm_addr  = mm_addr_q;
   assign mm_wdata = mm_wdata_q;
   assign err_cnt  = err_cnt_q;

endmodule
